// File: rtl/cipher_bus_master.sv
// Cipher bus initiator: feeds 128-bit blocks to the AES core and buffers its results.
// Latency: handshake -> i_data_valid next cycle; core o_data_valid -> rsp_valid next cycle.
// Backpressure: req_ready low on core-not-ready, gap cycle, mode drain or no credit; rsp held until rsp_ready.
//
// Ports:
//   clk, resetH                   clock, asynchronous active-high reset
//   req_valid/req_ready/req_data/req_ende   upstream block port (valid/ready)
//   rsp_valid/rsp_ready/rsp_data  downstream result port, first-word fall-through FIFO head
//   i_enable/i_ende/i_data/i_data_valid     request side of the core
//   o_ready/o_data_valid/o_data   result side of the core
//   outstanding                   blocks issued and not yet returned
//   err_spurious                  sticky: core result seen with nothing outstanding
module cipher_bus_master #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetH,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [127:0]           req_data,
  input  logic                   req_ende,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   i_enable,
  output logic                   i_ende,
  output logic [127:0]           i_data,
  output logic                   i_data_valid,
  input  logic                   o_ready,
  input  logic                   o_data_valid,
  input  logic [127:0]           o_data,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_spurious
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_U = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_enable;
  logic            r_ende;
  logic [127:0]    r_data;
  logic            r_data_valid;
  logic            r_mode;
  logic            r_ready_q;
  logic [CW-1:0]   r_outstanding;
  logic            r_err;
  logic [CW-1:0]   r_fifo_cnt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [127:0]    r_mem [DEPTH];

  logic            w_mode_load;
  logic            w_out_nz;
  logic [CW:0]     w_used;
  logic            w_credit_ok;
  logic            w_issue_ok;
  logic            w_fire;
  logic            w_dec;
  logic            w_spur;
  logic            w_push;
  logic            w_pop;

  assign w_out_nz    = (r_outstanding != '0);
  // Credit counts both FIFO entries and in-flight blocks, so every result has a slot.
  assign w_used      = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
  assign w_credit_ok = (w_used < DEPTH_U);
  // r_data_valid low enforces the mandatory gap cycle between issues.
  assign w_issue_ok  = (r_state == S_RUN) && r_enable && r_ready_q && !r_data_valid &&
                       w_credit_ok && ((req_ende == r_mode) || !w_out_nz);
  assign w_fire      = req_valid && w_issue_ok;

  // Results with nothing outstanding are flagged and dropped, never pushed.
  assign w_dec  = o_data_valid && w_out_nz;
  assign w_spur = o_data_valid && !w_out_nz;
  assign w_push = w_dec;
  assign w_pop  = rsp_valid && rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_mode_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (req_valid && (req_ende != r_mode) && w_out_nz) w_state_nxt = S_DRAIN;
        else if (!req_valid && !w_out_nz && !w_fire)       w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (!w_out_nz) begin
          w_state_nxt = S_RUN;
          w_mode_load = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      r_state       <= S_IDLE;
      r_enable      <= 1'b0;
      r_ende        <= 1'b0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_mode        <= 1'b0;
      r_ready_q     <= 1'b0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_enable     <= (w_state_nxt != S_IDLE);
      r_ready_q    <= o_ready;
      r_data_valid <= w_fire;
      if (w_fire) begin
        r_data <= req_data;
        r_ende <= req_ende;
      end
      if (w_fire || w_mode_load) r_mode <= req_ende;
      if (w_fire && !w_dec)      r_outstanding <= r_outstanding + CW'(1);
      else if (!w_fire && w_dec) r_outstanding <= r_outstanding - CW'(1);
      if (w_spur) r_err <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CW'(1);
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CW'(1);
    end
  end

  // Storage needs no reset: only entries covered by r_fifo_cnt are ever presented.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= o_data;
  end

  assign req_ready    = w_issue_ok;
  assign rsp_valid    = (r_fifo_cnt != '0);
  assign rsp_data     = rsp_valid ? r_mem[r_rd_ptr] : '0;
  assign i_enable     = r_enable;
  assign i_ende       = r_ende;
  assign i_data       = r_data;
  assign i_data_valid = r_data_valid;
  assign outstanding  = r_outstanding;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_cipher_bus_master.sv
// Bench for cipher_bus_master: behavioural core model plus response scoreboard.
// Latency: model core returns each block core_lat cycles after its issue pulse.
// Backpressure: rsp_ready and o_ready are driven per test to exercise credit and ready gating.
module tb_cipher_bus_master;
  localparam int DEPTH = 4;
  localparam logic [127:0] K_ENC = 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  localparam logic [127:0] K_DEC = 128'hc3c3_7e7e_0101_fefe_8765_4321_0fed_cba9;
  localparam logic [127:0] D1    = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         resetH;
  logic         req_valid, req_ready, req_ende;
  logic [127:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         i_enable, i_ende, i_data_valid;
  logic [127:0] i_data;
  logic         o_ready, o_data_valid;
  logic [127:0] o_data;
  logic [$clog2(DEPTH):0] outstanding;
  logic         err_spurious;

  int n_chk = 0;
  int n_fail = 0;

  logic [127:0] sb[$];
  logic [127:0] pend_d[$];
  int           pend_t[$];
  int           core_lat;
  int           spur_req, spur_done;
  logic         spur_now;
  int           pulse_cnt = 0;
  int           pulse_cyc[$];
  int           ncyc = 0;
  logic         prev_idv = 1'b0;

  cipher_bus_master #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetH(resetH),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_ende(req_ende),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .i_enable(i_enable), .i_ende(i_ende), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_ready(o_ready), .o_data_valid(o_data_valid), .o_data(o_data),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic e);
    return d ^ (e ? K_DEC : K_ENC);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a block and holds req_valid; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [127:0] d, input logic e, output int waited);
    req_valid = 1'b1;
    req_data  = d;
    req_ende  = e;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(core_fn(d, e));
        @(posedge clk); #1;
        return;
      end
      waited++;
      if (waited >= 300) begin
        check_eq("handshake_timeout", 128'(waited), 128'd0);
        return;
      end
    end
  endtask

  task automatic rel();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && outstanding == 0 && !rsp_valid) break;
    end
    check_eq("drain_scoreboard_empty", 128'(sb.size()), 128'd0);
  endtask

  // Core model: registers issue pulses and returns results after core_lat cycles.
  initial begin
    int cyc;
    cyc = 0;
    spur_done = 0;
    spur_now = 1'b0;
    o_data_valid = 1'b0;
    o_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      o_data_valid = 1'b0;
      spur_now = 1'b0;
      if (resetH) begin
        pend_d.delete();
        pend_t.delete();
      end else begin
        if (spur_req != spur_done) begin
          spur_done = spur_req;
          o_data_valid = 1'b1;
          o_data = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
          spur_now = 1'b1;
        end else if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
          o_data_valid = 1'b1;
          o_data = pend_d.pop_front();
          void'(pend_t.pop_front());
        end
        if (i_data_valid) begin
          pend_d.push_back(core_fn(i_data, i_ende));
          pend_t.push_back(cyc + core_lat);
        end
      end
    end
  end

  // Cycle monitor: scoreboard pop, in-flight accounting, gap rule.
  always @(negedge clk) begin
    if (!resetH) begin
      check_eq("outstanding_vs_model", 128'(outstanding),
               128'(pend_d.size() + ((o_data_valid && !spur_now) ? 1 : 0)));
      check_eq("inflight_within_depth", 128'(sb.size() <= DEPTH), 128'd1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check_eq("rsp_unexpected", 128'(rsp_valid), 128'd0);
        else                check_eq("rsp_data", rsp_data, sb.pop_front());
      end
    end
    if (i_data_valid) begin
      check_eq("no_back_to_back_issue", 128'(prev_idv), 128'd0);
      pulse_cnt++;
      pulse_cyc.push_back(ncyc);
    end
    prev_idv = i_data_valid;
    ncyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p0;
    logic [127:0] dd;
    resetH = 1'b1; req_valid = 1'b0; req_data = '0; req_ende = 1'b0;
    rsp_ready = 1'b0; o_ready = 1'b1; core_lat = 3; spur_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_i_enable", 128'(i_enable), 128'd0);
    check_eq("rst_i_ende", 128'(i_ende), 128'd0);
    check_eq("rst_i_data_valid", 128'(i_data_valid), 128'd0);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_req_ready", 128'(req_ready), 128'd0);
    check_eq("rst_err_spurious", 128'(err_spurious), 128'd0);
    check_eq("rst_i_data", i_data, 128'd0);
    check_eq("rst_rsp_data", rsp_data, 128'd0);
    check_eq("rst_outstanding", 128'(outstanding), 128'd0);
    @(posedge clk); #1; resetH = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single encrypt: wake-up, one issue pulse, result lands in FIFO.
    send(D1, 1'b0, w);
    check_eq("wake_wait_cycles", 128'(w), 128'd1);
    rel();
    @(negedge clk);
    check_eq("single_i_data_valid", 128'(i_data_valid), 128'd1);
    check_eq("single_i_data", i_data, D1);
    check_eq("single_i_ende", 128'(i_ende), 128'd0);
    check_eq("single_i_enable", 128'(i_enable), 128'd1);
    check_eq("single_outstanding", 128'(outstanding), 128'd1);
    @(negedge clk);
    check_eq("single_pulse_end", 128'(i_data_valid), 128'd0);
    for (int i = 0; i < 50; i++) begin
      if (o_data_valid) break;
      @(negedge clk);
    end
    check_eq("single_core_result", 128'(o_data_valid), 128'd1);
    check_eq("single_rsp_not_yet", 128'(rsp_valid), 128'd0);
    @(negedge clk);
    check_eq("single_rsp_valid", 128'(rsp_valid), 128'd1);
    check_eq("single_rsp_data", rsp_data, core_fn(D1, 1'b0));
    check_eq("single_outstanding_back", 128'(outstanding), 128'd0);
    @(posedge clk); #1; rsp_ready = 1'b1;
    wait_drain();
    repeat (2) @(negedge clk);
    check_eq("idle_enable_drop", 128'(i_enable), 128'd0);
    check_eq("i_data_hold", i_data, D1);

    // Back-to-back with downstream stalled: credit caps issue at DEPTH.
    @(posedge clk); #1; rsp_ready = 1'b0;
    p0 = pulse_cnt;
    fork
      begin
        int wa;
        for (int i = 0; i < 6; i++) send(rnd128(), 1'b0, wa);
        rel();
      end
      begin
        repeat (40) @(negedge clk);
        check_eq("b2b_issued_at_stall", 128'(pulse_cnt - p0), 128'(DEPTH));
        check_eq("b2b_req_ready_low", 128'(req_ready), 128'd0);
        check_eq("b2b_fifo_full_valid", 128'(rsp_valid), 128'd1);
        @(posedge clk); #1; rsp_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("b2b_issued_total", 128'(pulse_cnt - p0), 128'd6);

    // Core not ready blocks issue; then gap rule with a continuous stream.
    @(posedge clk); #1; o_ready = 1'b0;
    p0 = pulse_cnt;
    fork
      begin
        int wg;
        send(rnd128(), 1'b0, wg);
        pulse_cyc.delete();
        for (int i = 0; i < 4; i++) send(rnd128(), 1'b0, wg);
        rel();
      end
      begin
        repeat (8) @(negedge clk);
        check_eq("ready_gate_no_issue", 128'(pulse_cnt - p0), 128'd0);
        @(posedge clk); #1; o_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("gap_pulse_count", 128'(pulse_cyc.size()), 128'd5);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check_eq("gap_period", 128'(pulse_cyc[i] - pulse_cyc[i-1]), 128'd2);

    // Mode switch: decrypt waits for all three encrypts to return.
    core_lat = 8;
    for (int i = 0; i < 3; i++) send(rnd128(), 1'b0, w);
    check_eq("mode_three_in_flight", 128'(outstanding), 128'd3);
    dd = rnd128();
    send(dd, 1'b1, w);
    rel();
    check_eq("mode_drain_waited", 128'(w >= 4), 128'd1);
    @(negedge clk);
    check_eq("mode_issue_pulse", 128'(i_data_valid), 128'd1);
    check_eq("mode_i_ende", 128'(i_ende), 128'd1);
    check_eq("mode_i_data", i_data, dd);
    check_eq("mode_outstanding_only_new", 128'(outstanding), 128'd1);
    wait_drain();
    core_lat = 3;

    // Spurious result: flagged, sticky, not pushed.
    check_eq("spur_before", 128'(err_spurious), 128'd0);
    @(posedge clk); #1; spur_req++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_data_valid) break;
    end
    @(negedge clk);
    check_eq("spur_flag", 128'(err_spurious), 128'd1);
    check_eq("spur_no_rsp", 128'(rsp_valid), 128'd0);
    check_eq("spur_outstanding", 128'(outstanding), 128'd0);
    repeat (5) @(negedge clk);
    check_eq("spur_sticky", 128'(err_spurious), 128'd1);

    // Reset mid-flight: async clear with two blocks outstanding.
    @(posedge clk); #1; core_lat = 8;
    send(rnd128(), 1'b0, w);
    send(rnd128(), 1'b0, w);
    rel();
    @(negedge clk);
    check_eq("midrst_two_out", 128'(outstanding), 128'd2);
    resetH = 1'b1;
    #1;
    sb.delete();
    check_eq("midrst_outstanding", 128'(outstanding), 128'd0);
    check_eq("midrst_i_enable", 128'(i_enable), 128'd0);
    check_eq("midrst_i_data", i_data, 128'd0);
    check_eq("midrst_i_data_valid", 128'(i_data_valid), 128'd0);
    check_eq("midrst_err", 128'(err_spurious), 128'd0);
    check_eq("midrst_req_ready", 128'(req_ready), 128'd0);
    repeat (2) @(posedge clk); #1;
    resetH = 1'b0; core_lat = 3;
    @(negedge clk);
    check_eq("postrst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("postrst_outstanding", 128'(outstanding), 128'd0);
    @(posedge clk); #1;
    send(rnd128(), 1'b0, w);
    rel();
    wait_drain();
    check_eq("postrst_no_spur", 128'(err_spurious), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
